// File: rtl/merge_pkg.sv
// Shared definitions for the merge-node input FIFOs: default record width, terminator
// value, count-width helper and the registered head-status bundle.
package merge_pkg;

   localparam int unsigned MERGE_DATA_W = 32;
   // The all-zero record marks the end of a sorted run
   localparam logic [MERGE_DATA_W-1:0] MERGE_TERMINATOR = '0;

   // Width able to hold 0..depth inclusive
   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic empty;
      logic min_zero;
      logic almost_full;
   } fifo_status_t;

endpackage

// File: rtl/merge_fifo_ram.sv
// Simple dual-port storage behind the FIFO head register. Synchronous write,
// combinational read so the head register can capture the oldest entry on a pop.
module merge_fifo_ram #(
   parameter int unsigned DataW = 32,
   parameter int unsigned Slots = 15,
   parameter int unsigned AddrW = 4
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [DataW-1:0] wdata_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [DataW-1:0] rdata_o
);

   logic [DataW-1:0] mem_q [Slots];

   // Contents need no reset; the pointers define which entries are live
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/merge_input_fifo.sv
// Per-input FWFT buffer feeding one side of a 2-way merge control stage.
// Head record, empty and terminator flags come straight from registers.
// Optional build macro MERGE_FIFO_STATS_EN enables the popped-terminator counter;
// without it o_run_count is tied to zero.
module merge_input_fifo
   import merge_pkg::*;
#(
   parameter int unsigned DATA_W       = MERGE_DATA_W,
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned AFULL_MARGIN = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_write,
   input  logic [DATA_W-1:0]          i_data,
   output logic                       o_full,
   output logic                       o_almost_full,
   input  logic                       i_pop,
   output logic [DATA_W-1:0]          o_data,
   output logic                       o_empty,
   output logic                       o_min_zero,
   output logic [cnt_w(DEPTH)-1:0]    o_count,
   output logic                       o_overflow,
   output logic                       o_underflow,
   output logic [15:0]                o_run_count
);

   localparam int unsigned CntW  = cnt_w(DEPTH);
   localparam int unsigned Slots = DEPTH - 1;
   localparam int unsigned PtrW  = $clog2(DEPTH);

   logic [DATA_W-1:0] head_q, head_d;
   fifo_status_t      stat_q, stat_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              ovf_q, unf_q;
   logic              head_valid_d, ram_empty, pop_ok, wr_ok, ram_we;
   logic [DATA_W-1:0] ram_rdata;

   // Slot count need not be a power of two, so wrap by compare
   function automatic logic [PtrW-1:0] nxt_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Slots - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign o_full    = (count_q == CntW'(DEPTH));
   // Head valid and count <= 1 means nothing sits behind the head
   assign ram_empty = (count_q <= CntW'(1));
   assign pop_ok    = i_pop & ~stat_q.empty;
   assign wr_ok     = i_write & (~o_full | i_pop);

   // Next-state for head, pointers and count
   always_comb begin
      head_d       = head_q;
      head_valid_d = ~stat_q.empty;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ram_we       = 1'b0;
      count_d      = count_q;

      if (pop_ok) begin
         if (!ram_empty) begin
            head_d   = ram_rdata;
            rd_ptr_d = nxt_ptr(rd_ptr_q);
         end else if (wr_ok) begin
            head_d = i_data;
         end else begin
            head_valid_d = 1'b0;
         end
      end

      if (wr_ok) begin
         if (stat_q.empty) begin
            head_d       = i_data;
            head_valid_d = 1'b1;
         end else if (!(pop_ok && ram_empty)) begin
            // Full case reads and writes the same slot; the read sees the old entry
            ram_we   = 1'b1;
            wr_ptr_d = nxt_ptr(wr_ptr_q);
         end
      end

      unique case ({wr_ok, pop_ok})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      stat_d.empty       = ~head_valid_d;
      stat_d.min_zero    = head_valid_d & (head_d == DATA_W'(MERGE_TERMINATOR));
      stat_d.almost_full = ((CntW'(DEPTH) - count_d) <= CntW'(AFULL_MARGIN));
   end

   // State registers; sticky error flags clear only on reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_q   <= '0;
         stat_q   <= '{empty: 1'b1, min_zero: 1'b0, almost_full: 1'b0};
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         head_q   <= head_d;
         stat_q   <= stat_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_q | (i_write & ~wr_ok);
         unf_q    <= unf_q | (i_pop & stat_q.empty);
      end
   end

   merge_fifo_ram #(
      .DataW (DATA_W),
      .Slots (Slots),
      .AddrW (PtrW)
   ) u_ram (
      .clk_i   (i_clk),
      .we_i    (ram_we),
      .waddr_i (wr_ptr_q),
      .wdata_i (i_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   assign o_data        = head_q;
   assign o_empty       = stat_q.empty;
   assign o_min_zero    = stat_q.min_zero;
   assign o_almost_full = stat_q.almost_full;
   assign o_count       = count_q;
   assign o_overflow    = ovf_q;
   assign o_underflow   = unf_q;

`ifdef MERGE_FIFO_STATS_EN
   logic [15:0] run_cnt_q;

   // Count terminators leaving the head; wraps naturally at 16 bits
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         run_cnt_q <= '0;
      end else if (pop_ok && stat_q.min_zero) begin
         run_cnt_q <= run_cnt_q + 16'd1;
      end
   end

   assign o_run_count = run_cnt_q;
`else
   assign o_run_count = '0;
`endif

endmodule
